// File: rtl/nibble_packer.sv
// Packs 4-bit nibbles, first nibble in the MSBs, into 32-bit words with one word of
// output buffering; FLUSH closes a partial word, zero-pads it and reports its length.
module nibble_packer #(
  parameter logic [3:0] PAD_NIBBLE = 4'h0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  NIB_IN,
  input  logic        NIB_VALID,
  output logic        NIB_READY,
  input  logic        FLUSH,
  output logic [31:0] WORD_OUT,
  output logic [3:0]  WORD_LEN,
  output logic        WORD_VALID,
  input  logic        WORD_READY
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned NIBS   = WORD_W / NIB_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [WORD_W-1:0]   acc, acc_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [WORD_W-1:0]   out_word, out_word_n;
  logic [CNT_W-1:0]    out_len, out_len_n;
  logic                out_full, out_full_n;

  logic                accept;
  logic                slot_free;
  logic                flush_take;
  logic                done;
  logic [WORD_W-1:0]   acc_ins;
  logic [WORD_W-1:0]   padded;
  logic [CNT_W-1:0]    cnt_ins;

  // State and datapath registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      out_word <= '0;
      out_len  <= '0;
      out_full <= 1'b0;
    end else begin
      state    <= state_n;
      acc      <= acc_n;
      cnt      <= cnt_n;
      out_word <= out_word_n;
      out_len  <= out_len_n;
      out_full <= out_full_n;
    end
  end

  // Next-state, accumulator insert/pad and output-slot management
  always_comb begin
    state_n    = state;
    acc_n      = acc;
    cnt_n      = cnt;
    out_word_n = out_word;
    out_len_n  = out_len;
    out_full_n = out_full;

    slot_free  = !out_full || WORD_READY;
    accept     = NIB_VALID && (state != HOLD);
    cnt_ins    = cnt + CNT_W'(accept);
    flush_take = FLUSH && ((state == FILL) || ((state == IDLE) && accept));
    done       = 1'b0;

    acc_ins = acc;
    for (int unsigned i = 0; i < NIBS; i++) begin
      if (accept && (CNT_W'(i) == cnt)) acc_ins[WORD_W-1-NIB_W*i -: NIB_W] = NIB_IN;
    end

    padded = acc_ins;
    for (int unsigned i = 0; i < NIBS; i++) begin
      if (CNT_W'(i) >= cnt_ins) padded[WORD_W-1-NIB_W*i -: NIB_W] = PAD_NIBBLE;
    end

    // A drained word frees the slot unless something new loads on the same edge
    if (out_full && WORD_READY) out_full_n = 1'b0;

    case (state)
      IDLE, FILL: begin
        done = (cnt_ins == CNT_W'(NIBS)) || flush_take;
        if (accept) begin
          acc_n   = acc_ins;
          cnt_n   = cnt_ins;
          state_n = FILL;
        end
        if (done) begin
          if (slot_free) begin
            out_word_n = padded;
            out_len_n  = cnt_ins;
            out_full_n = 1'b1;
            acc_n      = '0;
            cnt_n      = '0;
            state_n    = IDLE;
          end else begin
            acc_n   = padded;
            cnt_n   = cnt_ins;
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (slot_free) begin
          out_word_n = acc;
          out_len_n  = cnt;
          out_full_n = 1'b1;
          acc_n      = '0;
          cnt_n      = '0;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign NIB_READY  = (state != HOLD);
  assign WORD_OUT   = out_word;
  assign WORD_LEN   = out_len;
  assign WORD_VALID = out_full;

endmodule

// File: tb/tb_nibble_packer.sv
// Directed bench for nibble_packer: packing, streaming, backpressure, flush and reset cases.
module tb_nibble_packer;

  logic        CLK;
  logic        RESET;
  logic [3:0]  NIB_IN;
  logic        NIB_VALID;
  logic        NIB_READY;
  logic        FLUSH;
  logic [31:0] WORD_OUT;
  logic [3:0]  WORD_LEN;
  logic        WORD_VALID;
  logic        WORD_READY;

  logic        nib_ready_f;
  logic [31:0] word_out_f;
  logic [3:0]  word_len_f;
  logic        word_valid_f;

  int checks;
  int errors;

  nibble_packer dut (
    .CLK(CLK), .RESET(RESET), .NIB_IN(NIB_IN), .NIB_VALID(NIB_VALID),
    .NIB_READY(NIB_READY), .FLUSH(FLUSH), .WORD_OUT(WORD_OUT),
    .WORD_LEN(WORD_LEN), .WORD_VALID(WORD_VALID), .WORD_READY(WORD_READY)
  );

  nibble_packer #(.PAD_NIBBLE(4'hF)) dut_f (
    .CLK(CLK), .RESET(RESET), .NIB_IN(NIB_IN), .NIB_VALID(NIB_VALID),
    .NIB_READY(nib_ready_f), .FLUSH(FLUSH), .WORD_OUT(word_out_f),
    .WORD_LEN(word_len_f), .WORD_VALID(word_valid_f), .WORD_READY(WORD_READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Present one cycle of inputs, clock it, then settle just after the edge
  task automatic send(input logic [3:0] nib, input logic vld, input logic fl);
    NIB_IN    = nib;
    NIB_VALID = vld;
    FLUSH     = fl;
    @(posedge CLK);
    #1;
    NIB_VALID = 1'b0;
    FLUSH     = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_w;
    checks     = 0;
    errors     = 0;
    RESET      = 1'b1;
    NIB_IN     = 4'h0;
    NIB_VALID  = 1'b0;
    FLUSH      = 1'b0;
    WORD_READY = 1'b1;
    #12;
    check("rst_valid", 32'(WORD_VALID), 32'd0);
    check("rst_word", WORD_OUT, 32'h0);
    check("rst_len", 32'(WORD_LEN), 32'd0);
    check("rst_ready", 32'(NIB_READY), 32'd1);
    RESET = 1'b0;
    @(posedge CLK);
    #1;

    // Basic pack
    for (int i = 1; i <= 8; i++) begin
      check("basic_ready", 32'(NIB_READY), 32'd1);
      send(4'(i), 1'b1, 1'b0);
      if (i == 7) check("basic_not_yet", 32'(WORD_VALID), 32'd0);
    end
    check("basic_valid", 32'(WORD_VALID), 32'd1);
    check("basic_word", WORD_OUT, 32'h12345678);
    check("basic_len", 32'(WORD_LEN), 32'd8);
    send(4'h0, 1'b0, 1'b0);
    check("basic_one_cycle", 32'(WORD_VALID), 32'd0);

    // Streaming, 24 nibbles with no gaps
    for (int i = 0; i < 24; i++) begin
      check("stream_ready", 32'(NIB_READY), 32'd1);
      NIB_IN    = 4'(i % 16);
      NIB_VALID = 1'b1;
      @(posedge CLK);
      #1;
      if (i % 8 == 7) begin
        exp_w = (i == 15) ? 32'h89ABCDEF : 32'h01234567;
        check("stream_valid", 32'(WORD_VALID), 32'd1);
        check("stream_word", WORD_OUT, exp_w);
        check("stream_len", 32'(WORD_LEN), 32'd8);
      end
    end
    send(4'h0, 1'b0, 1'b0);
    check("stream_end", 32'(WORD_VALID), 32'd0);

    // Backpressure
    WORD_READY = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("bp_ready", 32'(NIB_READY), 32'd1);
      send(4'((10 + i) % 16), 1'b1, 1'b0);
      if (i >= 7) begin
        check("bp_hold_valid", 32'(WORD_VALID), 32'd1);
        check("bp_hold_word", WORD_OUT, 32'hABCDEF01);
      end
    end
    check("bp_in_hold", 32'(NIB_READY), 32'd0);
    send(4'h0, 1'b0, 1'b0);
    check("bp_still_hold", 32'(NIB_READY), 32'd0);
    check("bp_still_word", WORD_OUT, 32'hABCDEF01);
    WORD_READY = 1'b1;
    send(4'h0, 1'b0, 1'b0);
    check("bp_second_valid", 32'(WORD_VALID), 32'd1);
    check("bp_second_word", WORD_OUT, 32'h23456789);
    check("bp_second_len", 32'(WORD_LEN), 32'd8);
    check("bp_ready_back", 32'(NIB_READY), 32'd1);
    send(4'h0, 1'b0, 1'b0);
    check("bp_drained", 32'(WORD_VALID), 32'd0);

    // Flush partial word
    send(4'h9, 1'b1, 1'b0);
    send(4'hC, 1'b1, 1'b0);
    send(4'h3, 1'b1, 1'b0);
    check("fl_not_yet", 32'(WORD_VALID), 32'd0);
    send(4'h0, 1'b0, 1'b1);
    check("fl_valid", 32'(WORD_VALID), 32'd1);
    check("fl_word", WORD_OUT, 32'h9C300000);
    check("fl_len", 32'(WORD_LEN), 32'd3);
    check("flf_word", word_out_f, 32'h9C3FFFFF);
    check("flf_len", 32'(word_len_f), 32'd3);
    send(4'h0, 1'b0, 1'b0);
    check("fl_drained", 32'(WORD_VALID), 32'd0);

    // Flush in IDLE without a nibble emits nothing
    send(4'h0, 1'b0, 1'b1);
    check("fl_idle", 32'(WORD_VALID), 32'd0);
    send(4'h0, 1'b0, 1'b0);
    check("fl_idle_after", 32'(WORD_VALID), 32'd0);

    // Flush with the first nibble
    send(4'h5, 1'b1, 1'b1);
    check("fl1_word", WORD_OUT, 32'h50000000);
    check("fl1_len", 32'(WORD_LEN), 32'd1);
    check("fl1f_word", word_out_f, 32'h5FFFFFFF);
    send(4'h0, 1'b0, 1'b0);

    // Flush with the 8th nibble is a normal completion
    for (int i = 1; i <= 7; i++) send(4'(i), 1'b1, 1'b0);
    send(4'h8, 1'b1, 1'b1);
    check("fl8_word", WORD_OUT, 32'h12345678);
    check("fl8_len", 32'(WORD_LEN), 32'd8);
    check("fl8f_word", word_out_f, 32'h12345678);
    send(4'h0, 1'b0, 1'b0);

    // Reset mid-operation with a word held and a partial word pending
    WORD_READY = 1'b0;
    for (int i = 1; i <= 8; i++) send(4'(i), 1'b1, 1'b0);
    for (int i = 9; i <= 13; i++) send(4'(i), 1'b1, 1'b0);
    check("mr_pre_valid", 32'(WORD_VALID), 32'd1);
    #2;
    RESET = 1'b1;
    #1;
    check("mr_valid", 32'(WORD_VALID), 32'd0);
    check("mr_word", WORD_OUT, 32'h0);
    check("mr_len", 32'(WORD_LEN), 32'd0);
    check("mr_ready", 32'(NIB_READY), 32'd1);
    RESET = 1'b0;
    WORD_READY = 1'b1;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 8; i++) send(4'(15 - i), 1'b1, 1'b0);
    check("mr_word_after", WORD_OUT, 32'hFEDCBA98);
    check("mr_len_after", 32'(WORD_LEN), 32'd8);
    check("mr_valid_after", 32'(WORD_VALID), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_packer.md
# nibble_packer

Receiving end of the nibble selection path: collects the 4-bit nibbles that the nibble block produces on DATA_OUT and packs them, MSB nibble first, into 32-bit words. Upstream and downstream use valid/ready handshakes, with one word of output buffering, so one nibble per cycle is sustained while the word consumer keeps up. A flush input closes a partial word, zero-pads it and reports its length.

## Interface
- PAD_NIBBLE, 4'h0, value written into unfilled nibble slots of a flushed partial word.
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- NIB_IN  input  4  incoming nibble.
- NIB_VALID  input  1  NIB_IN is valid this cycle.
- NIB_READY  output  1  packer accepts a nibble this cycle. A nibble transfers when NIB_VALID and NIB_READY are both 1.
- FLUSH  input  1  single-cycle request to close the current partial word.
- WORD_OUT  output  32  packed word; the first nibble received is in [31:28].
- WORD_LEN  output  4  number of real nibbles in WORD_OUT, 1..8.
- WORD_VALID  output  1  WORD_OUT and WORD_LEN are valid.
- WORD_READY  input  1  consumer takes the word. A word transfers when WORD_VALID and WORD_READY are both 1.

## Operation
- **Accumulator:** acc[31:0] and cnt[3:0] (0..8).
  - An accepted nibble goes into slot cnt: bits [31-4*cnt -: 4].
  - cnt then increments.
- **Output register:** out_word, out_len, out_full. WORD_VALID = out_full.
- **Drain:** drain = WORD_VALID & WORD_READY. The output slot is free this cycle when !out_full | drain.
- **Accumulator states:**
  - IDLE: cnt = 0.
  - FILL: 1 ≤ cnt ≤ 7.
  - HOLD: cnt = 8, completed word waiting for the output slot.
- **Transitions:**
  - IDLE→FILL on an accepted nibble.
  - FILL→HOLD when the 8th nibble is accepted and the slot is not free.
  - FILL→IDLE when the 8th nibble is accepted and the slot is free. The word moves to the output register on the same edge with len 8.
  - HOLD→IDLE when the slot is free; the held word moves out with len 8.
- **NIB_READY** = (state != HOLD). It is combinational from state only and never depends on NIB_VALID.
- **FLUSH** is honoured only in FILL, or when a nibble is accepted in IDLE in the same cycle.
  - The same-cycle nibble is included first.
  - Unfilled slots are set to PAD_NIBBLE.
  - len = cnt after the nibble is included.
  - If the slot is free, the word moves out and state goes to IDLE. Otherwise state goes to HOLD with the padded word and the recorded len, and NIB_READY drops.
- **FLUSH ignored:** in IDLE with no nibble accepted (no zero-length word is ever emitted), and in HOLD (the word is already complete).
- **FLUSH on the 8th nibble** is equivalent to a normal completion: len 8, no padding.
- **Widths:** cnt saturates at 8 and never wraps. WORD_LEN is 4 bits, so 8 = 4'b1000.
- **Reset (asynchronous, RESET = 1):**
  - acc = 0, cnt = 0, state IDLE.
  - out_word = 0, out_len = 0, out_full = 0.
  - Outputs: WORD_VALID = 0, WORD_OUT = 0, WORD_LEN = 0, NIB_READY = 1.
  - A partial or held word is discarded. The first nibble after reset release lands in [31:28].

## Timing
- Latency: WORD_VALID rises on the edge that accepts the 8th nibble (or the flush), provided the slot is free.
- The word can be consumed the following cycle, one clock after the last nibble is presented.
- Throughput: with WORD_READY tied high, 8 nibbles per word and no bubbles. NIB_READY stays 1 continuously and a word appears every 8 cycles.
- WORD_OUT, WORD_LEN and WORD_VALID are registered and stay stable while WORD_VALID = 1 and WORD_READY = 0.
- **Simultaneous drain and completion:** the old word leaves and the new word loads on the same edge. WORD_VALID stays 1 with no gap.
- **HOLD exit:** one cycle after the slot frees, NIB_READY returns to 1. That cycle transfers the held word, so no nibble is lost.

## Test plan
- **Basic pack:** reset, then nibbles 1,2,3,4,5,6,7,8 on consecutive cycles, WORD_READY = 1 -> one cycle after the 8th, WORD_OUT = 32'h12345678, WORD_LEN = 8, WORD_VALID high one cycle, NIB_READY always 1.
- **Streaming:** 24 nibbles 0..F,0..7 with no gaps, WORD_READY = 1 -> words 32'h01234567, 32'h89ABCDEF, 32'h01234567, each with WORD_LEN 8, no NIB_READY deassertion.
- **Backpressure:** WORD_READY = 0 while 16 nibbles A..(A+15 mod 16) are offered -> first word held stable. NIB_READY = 0 after the 16th nibble (HOLD). Raising WORD_READY delivers the second word on the next cycle and NIB_READY returns to 1; no nibble is dropped or duplicated.
- **Flush partial:** nibbles 9,C,3, then FLUSH alone -> WORD_OUT = 32'h9C300000, WORD_LEN = 3. Repeat with PAD_NIBBLE = 4'hF -> 32'h9C3FFFFF.
- **Flush corner cases:**
  - FLUSH in IDLE with no nibble -> nothing emitted.
  - FLUSH together with the first nibble 5 -> 32'h50000000, WORD_LEN 1.
  - FLUSH together with the 8th nibble -> normal len-8 word.
- **Reset mid-operation:** assert RESET asynchronously (between edges) after 5 nibbles with a word held in the output register -> WORD_VALID, WORD_OUT and WORD_LEN drop to 0 immediately, NIB_READY = 1. The next 8 nibbles pack from [31:28].
